// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions so the multiplier
// and the accumulator lane agree on product width and stream length.
package sc_pkg;

  localparam int SC_PROD_WIDTH    = 5;
  localparam int SC_STREAM_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } sc_state_e;

endpackage

// File: rtl/sc_sat_add.sv
// Combinational saturating adder: unsigned accumulator plus a
// zero-extended product, clamped at the accumulator's full scale.
module sc_sat_add #(
  parameter int ACC_WIDTH  = 12,
  parameter int PROD_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [PROD_WIDTH-1:0] add_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  ovf_o
);

  localparam int RW = ACC_WIDTH + 1;

  logic [RW-1:0] raw;

  // One guard bit is enough while the product is no wider than acc
  assign raw   = {1'b0, acc_i} + RW'(add_i);
  assign ovf_o = raw[ACC_WIDTH];
  assign sum_o = ovf_o ? '1 : raw[ACC_WIDTH-1:0];

endmodule

// File: rtl/sc_dot_accum.sv
// Reduction stage of an SC MAC lane: sums a programmed number of
// product counts into one saturating dot-product result.
module sc_dot_accum
  import sc_pkg::*;
#(
  parameter int PROD_WIDTH = SC_PROD_WIDTH,
  parameter int ACC_WIDTH  = 12,
  parameter int MAX_TERMS  = SC_STREAM_LENGTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_terms,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_sat,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_TERMS);

  sc_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  terms_q, terms_d;
  logic [ACC_WIDTH-1:0]  res_q, res_d;
  logic                  sat_q, sat_d;

  logic [ACC_WIDTH-1:0]  sum;
  logic                  ovf;
  logic [CNT_WIDTH-1:0]  count_inc;

  sc_sat_add #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_add (
    .acc_i (acc_q),
    .add_i (prod_data),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  assign count_inc = count_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    terms_d = terms_q;
    res_d   = res_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          terms_d = (cfg_terms > MAX_C) ? MAX_C : cfg_terms;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          if (cfg_terms == '0) begin
            state_d = HOLD;
            res_d   = '0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_d   = sum;
          count_d = count_inc;
          if (ovf) sat_d = 1'b1;
          // Final beat publishes the sum on the same edge
          if (count_inc == terms_q) begin
            state_d = HOLD;
            res_d   = sum;
          end
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      terms_q <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      terms_q <= terms_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign res_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign res_data   = res_q;
  assign res_sat    = sat_q;

endmodule

// File: tb/tb_sc_dot_accum.sv
// Randomised bench for sc_dot_accum: default 12-bit lane plus a
// 6-bit lane driven in lockstep to exercise saturation.
module tb_sc_dot_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prod_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [4:0] cfg_terms = '0;
  logic [4:0] prod_data = '0;

  logic        a_prdy, a_rv, a_sat, a_busy;
  logic [11:0] a_res;
  logic        b_prdy, b_rv, b_sat, b_busy;
  logic [5:0]  b_res;

  int n_chk = 0;
  int n_fail = 0;
  int pq[$];

  always #5 clk = ~clk;

  sc_dot_accum u_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_terms  (cfg_terms),
    .prod_valid (prod_valid),
    .prod_ready (a_prdy),
    .prod_data  (prod_data),
    .res_valid  (a_rv),
    .res_ready  (res_ready),
    .res_data   (a_res),
    .res_sat    (a_sat),
    .busy       (a_busy)
  );

  sc_dot_accum #(.ACC_WIDTH(6)) u_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_terms  (cfg_terms),
    .prod_valid (prod_valid),
    .prod_ready (b_prdy),
    .prod_data  (prod_data),
    .res_valid  (b_rv),
    .res_ready  (res_ready),
    .res_data   (b_res),
    .res_sat    (b_sat),
    .busy       (b_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampw(input int total, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (total > mx) ? mx : total;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_prdy_a"}, a_prdy, 0);
    check({tag, "_rv_a"}, a_rv, 0);
    check({tag, "_busy_a"}, a_busy, 0);
    check({tag, "_res_a"}, a_res, 0);
    check({tag, "_sat_a"}, a_sat, 0);
    check({tag, "_prdy_b"}, b_prdy, 0);
    check({tag, "_rv_b"}, b_rv, 0);
    check({tag, "_busy_b"}, b_busy, 0);
    check({tag, "_res_b"}, b_res, 0);
    check({tag, "_sat_b"}, b_sat, 0);
  endtask

  // Runs one operation on the first min(cfg,16) entries of pq
  task automatic run_op(input int cfg, input int gap,
                        input int hold, input bit poke);
    int n, total, k, cyc;
    bit v, rdy;
    n = (cfg > 16) ? 16 : cfg;
    total = 0;
    for (int i = 0; i < n; i++) total += pq[i];
    start = 1'b1;
    cfg_terms = 5'(cfg);
    res_ready = poke;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", a_busy, 1);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 500) begin
      check("rv_early", a_rv, 0);
      check("prdy_accum", a_prdy, 1);
      v = ($urandom_range(0, 99) >= gap);
      prod_valid = v;
      prod_data = 5'(pq[k]);
      rdy = a_prdy;
      @(negedge clk);
      cyc++;
      if (v && rdy) k++;
    end
    prod_valid = 1'b0;
    res_ready = 1'b0;
    check("accepted", k, n);
    for (int h = 0; h <= hold; h++) begin
      check("rv_a", a_rv, 1);
      check("rv_b", b_rv, 1);
      check("prdy_hold", a_prdy, 0);
      check("res_a", a_res, clampw(total, 12));
      check("sat_a", a_sat, total > 4095);
      check("res_b", b_res, clampw(total, 6));
      check("sat_b", b_sat, total > 63);
      start = poke;
      res_ready = (h == hold);
      @(negedge clk);
    end
    res_ready = 1'b0;
    start = 1'b0;
    check("rv_drop_a", a_rv, 0);
    check("rv_drop_b", b_rv, 0);
    check("busy_idle_a", a_busy, 0);
    check("busy_idle_b", b_busy, 0);
  endtask

  initial begin
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pq = '{16, 8, 1, 0};
    run_op(4, 0, 0, 1'b0);

    pq = '{5, 7, 2};
    run_op(3, 50, 5, 1'b1);

    pq = '{16, 16, 16, 16, 16};
    run_op(5, 0, 1, 1'b0);

    pq = '{3};
    run_op(1, 20, 0, 1'b0);

    pq = '{};
    run_op(0, 0, 2, 1'b0);

    // Abort an operation halfway through
    start = 1'b1;
    cfg_terms = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_data = 5'd30;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    check("mid_busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pq = '{9, 9};
    run_op(2, 0, 0, 1'b0);

    pq = '{};
    for (int i = 0; i < 20; i++) pq.push_back($urandom_range(0, 31));
    run_op(31, 25, 0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      pq = '{};
      for (int i = 0; i < 16; i++) pq.push_back($urandom_range(0, 31));
      run_op($urandom_range(0, 20), 30, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
